// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the UART-to-ALU frame controller: FSM state encoding
// and bit positions inside the transmitted flags byte.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_B,
    ST_WAIT_OP,
    ST_EXEC,
    ST_SEND_RES,
    ST_WAIT_TX,
    ST_SEND_FLG
  } state_e;

  localparam int unsigned FLG_ZERO_BIT = 0;
  localparam int unsigned FLG_OVF_BIT  = 1;

endpackage

// File: rtl/alu_uart_ctrl_frame_timer.sv
// Inter-byte idle counter: cleared on demand, counts while enabled, and
// strobes expire_o on the enabled cycle where the count sits at TIMEOUT_CYCLES-1.
module frame_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic I_clk,
  input  logic I_reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expire_o = en_i && (count_q == LAST);

endmodule

// File: rtl/alu_uart_ctrl.sv
// Frame sequencer between a UART rx/tx pair and the ALU: collects A, B, op,
// returns the result byte. Define ALU_CTRL_FLAGS_EN to also send a flags byte.
module alu_uart_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned NB_DATA        = 8,
  parameter int unsigned NB_OP          = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               I_clk,
  input  logic               I_reset,
  input  logic [NB_DATA-1:0] I_rx_data,
  input  logic               I_rx_done,
  input  logic               I_tx_busy,
  input  logic               I_tx_done,
  input  logic [NB_DATA-1:0] I_alu_result,
  input  logic               I_alu_overflow,
  input  logic               I_alu_zero,
  output logic [NB_DATA-1:0] O_data_a,
  output logic [NB_DATA-1:0] O_data_b,
  output logic [NB_OP-1:0]   O_op_code,
  output logic [NB_DATA-1:0] O_tx_data,
  output logic               O_tx_start,
  output logic               O_busy,
  output logic               O_frame_err
);

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] a_q, a_d, b_q, b_d, txd_q, txd_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic               ferr_q;
  logic               tx_start;
  logic               tmr_clr, tmr_en, tmr_exp;
`ifdef ALU_CTRL_FLAGS_EN
  logic [1:0]         flg_q, flg_d;
  logic               flg_sent_q, flg_sent_d;
`else
  logic               unused_alu_flags;
  assign unused_alu_flags = I_alu_overflow ^ I_alu_zero;
`endif

  frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .I_clk    (I_clk),
    .I_reset  (I_reset),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (tmr_exp)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    txd_d    = txd_q;
    tx_start = 1'b0;
    tmr_clr  = 1'b1;
    tmr_en   = 1'b0;
`ifdef ALU_CTRL_FLAGS_EN
    flg_d      = flg_q;
    flg_sent_d = flg_sent_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (I_rx_done) begin
          a_d     = I_rx_data;
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        tmr_clr = I_rx_done;
        tmr_en  = !I_rx_done;
        if (I_rx_done) begin
          b_d     = I_rx_data;
          state_d = ST_WAIT_OP;
        end else if (tmr_exp) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_OP: begin
        tmr_clr = I_rx_done;
        tmr_en  = !I_rx_done;
        if (I_rx_done) begin
          op_d    = I_rx_data[NB_OP-1:0];
          state_d = ST_EXEC;
        end else if (tmr_exp) begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        // Result is loaded straight into the tx register so the start strobe
        // can be raised in the very next cycle with the data already stable.
        txd_d   = I_alu_result;
`ifdef ALU_CTRL_FLAGS_EN
        flg_d      = {I_alu_overflow, I_alu_zero};
        flg_sent_d = 1'b0;
`endif
        state_d = ST_SEND_RES;
      end
      ST_SEND_RES: begin
        if (!I_tx_busy) begin
          tx_start = 1'b1;
          state_d  = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        if (I_tx_done) begin
`ifdef ALU_CTRL_FLAGS_EN
          if (flg_sent_q) begin
            state_d = ST_IDLE;
          end else begin
            txd_d              = '0;
            txd_d[FLG_OVF_BIT]  = flg_q[1];
            txd_d[FLG_ZERO_BIT] = flg_q[0];
            state_d            = ST_SEND_FLG;
          end
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef ALU_CTRL_FLAGS_EN
      ST_SEND_FLG: begin
        if (!I_tx_busy) begin
          tx_start   = 1'b1;
          flg_sent_d = 1'b1;
          state_d    = ST_WAIT_TX;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      txd_q   <= '0;
      ferr_q  <= 1'b0;
`ifdef ALU_CTRL_FLAGS_EN
      flg_q      <= '0;
      flg_sent_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      txd_q   <= txd_d;
      ferr_q  <= tmr_exp;
`ifdef ALU_CTRL_FLAGS_EN
      flg_q      <= flg_d;
      flg_sent_q <= flg_sent_d;
`endif
    end
  end

  assign O_data_a    = a_q;
  assign O_data_b    = b_q;
  assign O_op_code   = op_q;
  assign O_tx_data   = txd_q;
  assign O_tx_start  = tx_start;
  assign O_busy      = (state_q != ST_IDLE);
  assign O_frame_err = ferr_q;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed bench for alu_uart_ctrl with a small ADD-only ALU stand-in;
// flags-byte checks are compiled in when ALU_CTRL_FLAGS_EN is defined.
module tb_alu_uart_ctrl;

  localparam int unsigned NB_DATA = 8;
  localparam int unsigned NB_OP   = 6;
  localparam int unsigned TMO     = 16;

  logic               clk, rst;
  logic [NB_DATA-1:0] rx_data;
  logic               rx_done, tx_busy, tx_done;
  logic [NB_DATA-1:0] alu_res;
  logic               alu_ovf, alu_zero;
  logic [NB_DATA-1:0] data_a, data_b, tx_data;
  logic [NB_OP-1:0]   op_code;
  logic               tx_start, busy, frame_err;

  int n_cmp = 0;
  int n_err = 0;

  alu_uart_ctrl #(
    .NB_DATA        (NB_DATA),
    .NB_OP          (NB_OP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .I_clk          (clk),
    .I_reset        (rst),
    .I_rx_data      (rx_data),
    .I_rx_done      (rx_done),
    .I_tx_busy      (tx_busy),
    .I_tx_done      (tx_done),
    .I_alu_result   (alu_res),
    .I_alu_overflow (alu_ovf),
    .I_alu_zero     (alu_zero),
    .O_data_a       (data_a),
    .O_data_b       (data_b),
    .O_op_code      (op_code),
    .O_tx_data      (tx_data),
    .O_tx_start     (tx_start),
    .O_busy         (busy),
    .O_frame_err    (frame_err)
  );

  // ALU stand-in: op 0x20 is ADD with signed overflow, anything else yields 0.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    if (op_code == 6'h20) begin
      alu_res = data_a + data_b;
      alu_ovf = (data_a[7] == data_b[7]) && (alu_res[7] != data_a[7]);
    end
    alu_zero = (alu_res == '0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
  endtask

  // Called in the cycle where the result start strobe is visible.
  task automatic finish_frame(input logic [7:0] exp_res, input logic [7:0] exp_flg);
    check("res_start", tx_start, 1);
    check("res_data", tx_data, exp_res);
    @(posedge clk); #1;
    check("start_one_cycle", tx_start, 0);
    check("hold_data", tx_data, exp_res);
    pulse_tx_done();
`ifdef ALU_CTRL_FLAGS_EN
    check("flg_start", tx_start, 1);
    check("flg_data", tx_data, exp_flg);
    @(posedge clk); #1;
    check("flg_start_one_cycle", tx_start, 0);
    pulse_tx_done();
`else
    check("no_flag_byte", {24'd0, exp_flg} & 32'd0 | {31'd0, tx_start}, 0);
`endif
    check("idle_after_frame", busy, 0);
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input logic [7:0] exp_res, input logic [7:0] exp_flg);
    send_byte(a);
    send_byte(b);
    send_byte(op);
    check("exec_no_start", tx_start, 0);
    @(posedge clk); #1;
    finish_frame(exp_res, exp_flg);
  endtask

  initial begin
    rst = 1'b1; rx_data = '0; rx_done = 1'b0; tx_busy = 1'b0; tx_done = 1'b0;
    #12;
    check("rst_data_a", data_a, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_tx_data", tx_data, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Basic ADD frame: start two cycles after the op byte.
    send_byte(8'h05);
    check("a_latched", data_a, 8'h05);
    check("busy_wait_b", busy, 1);
    send_byte(8'h03);
    check("b_latched", data_b, 8'h03);
    send_byte(8'h20);
    check("op_latched", op_code, 6'h20);
    check("exec_no_start", tx_start, 0);
    @(posedge clk); #1;
    finish_frame(8'h08, 8'h00);

    // Transmitter busy for 10 cycles after EXEC.
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h20);
    tx_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("busy_hold_start", tx_start, 0);
    end
    check("busy_hold_state", busy, 1);
    tx_busy = 1'b0;
    #1;
    finish_frame(8'h08, 8'h00);

    // Inter-byte timeout in WAIT_OP.
    send_byte(8'h05);
    send_byte(8'h03);
    repeat (TMO - 1) @(posedge clk);
    #1;
    check("tmo_not_yet", frame_err, 0);
    check("tmo_still_busy", busy, 1);
    @(posedge clk); #1;
    check("tmo_pulse", frame_err, 1);
    check("tmo_idle", busy, 0);
    check("tmo_keep_a", data_a, 8'h05);
    check("tmo_keep_b", data_b, 8'h03);
    @(posedge clk); #1;
    check("tmo_pulse_width", frame_err, 0);
    run_frame(8'h01, 8'h01, 8'h20, 8'h02, 8'h00);

    // Byte arriving on the expiry cycle is accepted.
    send_byte(8'h09);
    repeat (TMO - 1) @(posedge clk);
    #1;
    send_byte(8'h04);
    check("edge_b_taken", data_b, 8'h04);
    check("edge_no_err", frame_err, 0);
    check("edge_busy", busy, 1);
    send_byte(8'h20);
    @(posedge clk); #1;
    finish_frame(8'h0D, 8'h00);

    // Stray byte while waiting for tx_done; op byte upper bits discarded.
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'hE0);
    check("op_trunc", op_code, 6'h20);
    @(posedge clk); #1;
    check("stray_res_start", tx_start, 1);
    @(posedge clk); #1;
    send_byte(8'hFF);
    check("stray_keep_a", data_a, 8'h11);
    check("stray_busy", busy, 1);
    check("stray_keep_data", tx_data, 8'h33);
    pulse_tx_done();
`ifdef ALU_CTRL_FLAGS_EN
    check("stray_flg", tx_data, 8'h00);
    @(posedge clk); #1;
    pulse_tx_done();
`endif
    check("stray_idle", busy, 0);
    run_frame(8'h02, 8'h03, 8'h20, 8'h05, 8'h00);

    // Asynchronous reset in WAIT_OP.
    send_byte(8'h05);
    send_byte(8'h03);
    #2 rst = 1'b1;
    #1;
    check("arst_a", data_a, 0);
    check("arst_b", data_b, 0);
    check("arst_busy", busy, 0);
    check("arst_start", tx_start, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("arst_idle", busy, 0);
    run_frame(8'h05, 8'h03, 8'h20, 8'h08, 8'h00);

    // Signed overflow: flags byte carries overflow=1, zero=0.
    run_frame(8'h7F, 8'h01, 8'h20, 8'h80, 8'h02);
    // Zero result: 0x80 + 0x80 wraps to 0 with overflow.
    run_frame(8'h80, 8'h80, 8'h20, 8'h00, 8'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_uart_ctrl.md
# alu_uart_ctrl

Frame-sequencing controller placed between a UART receiver/transmitter pair and the shared `alu` datapath. It collects three received bytes (operand A, operand B, operation code), drives them into the ALU, captures the result one cycle later and ships it back through the transmitter with a start/done handshake. A per-frame inter-byte timeout discards partial frames.

## Interface
- `NB_DATA`, 8, operand/result/UART byte width
- `NB_OP`, 6, ALU operation-code width (≤ NB_DATA)
- `TIMEOUT_CYCLES`, 1_000_000, max idle cycles between bytes of one frame
- `I_clk`  in  1  single clock, rising edge
- `I_reset`  in  1  asynchronous, active-high reset
- `I_rx_data`  in  NB_DATA  received byte, valid while `I_rx_done`
- `I_rx_done`  in  1  one-cycle strobe: byte received
- `I_tx_busy`  in  1  transmitter busy
- `I_tx_done`  in  1  one-cycle strobe: byte transmitted
- `I_alu_result`  in  NB_DATA  ALU result
- `I_alu_overflow`  in  1  ALU overflow flag
- `I_alu_zero`  in  1  ALU zero flag
- `O_data_a`  out  NB_DATA  registered operand A to ALU
- `O_data_b`  out  NB_DATA  registered operand B to ALU
- `O_op_code`  out  NB_OP  registered op code to ALU
- `O_tx_data`  out  NB_DATA  byte to transmit, stable from `O_tx_start` until `I_tx_done`
- `O_tx_start`  out  1  one-cycle transmit request
- `O_busy`  out  1  high in every state except IDLE
- `O_frame_err`  out  1  one-cycle pulse on timeout abort

## Operation
- Reset: state IDLE; all outputs 0; timer 0.
- IDLE: on `I_rx_done` → `O_data_a <= I_rx_data`, go WAIT_B, timer cleared.
- WAIT_B: on `I_rx_done` → `O_data_b <= I_rx_data`, go WAIT_OP, timer cleared.
- WAIT_OP: on `I_rx_done` → `O_op_code <= I_rx_data[NB_OP-1:0]` (upper bits discarded), go EXEC.
- EXEC: one cycle for combinational ALU to settle; latch `I_alu_result`, `I_alu_overflow`, `I_alu_zero` into internal result registers; go SEND_RES.
- SEND_RES: when `I_tx_busy`=0 → `O_tx_data <= result`, pulse `O_tx_start`, go WAIT_TX; else hold.
- WAIT_TX: on `I_tx_done` → IDLE (or SEND_FLG, see Configuration).
- Timeout: in WAIT_B/WAIT_OP timer increments each cycle without `I_rx_done`; when it reaches TIMEOUT_CYCLES-1 → IDLE, pulse `O_frame_err`; `O_data_a/b/op_code` retain values.
- `I_rx_done` in EXEC/SEND_RES/WAIT_TX/SEND_FLG: byte dropped, no state change.
- `I_rx_done` in the same cycle the timer expires: byte accepted, no abort.
- `I_reset` mid-frame or mid-transmit: immediate return to reset state; any pending `O_tx_start` dropped.

## Timing
- `I_rx_done` at cycle n → operand/op register updated, visible n+1.
- Op byte at cycle m → EXEC at m+1, result latched at end of m+1, `O_tx_start` at m+2 earliest (later if `I_tx_busy`).
- `O_tx_start` is exactly one cycle wide; never asserted while `I_tx_busy`=1.
- Back-to-back frames: first byte of next frame accepted in the cycle after WAIT_TX exits.

## Configuration
- `ALU_CTRL_FLAGS_EN` defined: after result byte, state SEND_FLG sends a second byte `{zeros, overflow, zero}` (bit1=overflow, bit0=zero) with identical start/busy/done handshake, then IDLE.
- Undefined: SEND_FLG absent; WAIT_TX → IDLE; flags not transmitted.

## Structure
- Package `alu_ctrl_pkg`: state encoding (IDLE, WAIT_B, WAIT_OP, EXEC, SEND_RES, WAIT_TX, SEND_FLG), flags-byte bit positions.
- Sub-module `frame_timer`: counter with clear/enable inputs, expiry strobe at TIMEOUT_CYCLES-1.

## Test plan
- Bench with real `alu`: bytes 0x05, 0x03, 0x20 (ADD) → `O_tx_start` 2 cycles after op byte, `O_tx_data`=0x08.
- `I_tx_busy` held high 10 cycles after EXEC → `O_tx_start` delayed until busy falls, single pulse, data 0x08.
- Bytes 0x05, 0x03 then silence TIMEOUT_CYCLES (set 16) → `O_frame_err` pulse, state IDLE; next frame 0x01, 0x01, 0x20 → 0x02.
- Extra byte 0xFF during WAIT_TX → ignored; `O_data_a` unchanged, next frame unaffected.
- `I_reset` asserted in WAIT_OP → all outputs 0 asynchronously, IDLE after release.
- With `ALU_CTRL_FLAGS_EN`: 0x7F, 0x01, 0x20 → result 0x80 then flags byte 0x02.
